// File: rtl/axis_dp_demux_pkt.sv
// rtl/axis_dp_demux_pkt.sv - packet-granular AXI-Stream demux with per-packet select and drop counter
module axis_dp_demux_pkt #(
  parameter int M_COUNT    = 2,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 9,
  parameter int USER_WIDTH = 97,
  parameter int SEL_WIDTH  = (M_COUNT > 1 ? $clog2(M_COUNT) : 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,

  input  logic [DATA_WIDTH-1:0]            s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]            s_axis_tkeep,
  input  logic [USER_WIDTH-1:0]            s_axis_tuser,
  input  logic [ID_WIDTH-1:0]              s_axis_tid,
  input  logic [DEST_WIDTH-1:0]            s_axis_tdest,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic                             s_axis_tlast,

  input  logic                             sel_valid,
  output logic                             sel_ready,
  input  logic [SEL_WIDTH-1:0]             sel_port,
  input  logic                             sel_drop,

  output logic [M_COUNT*DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [M_COUNT*KEEP_WIDTH-1:0]    m_axis_tkeep,
  output logic [M_COUNT*USER_WIDTH-1:0]    m_axis_tuser,
  output logic [M_COUNT*ID_WIDTH-1:0]      m_axis_tid,
  output logic [M_COUNT*DEST_WIDTH-1:0]    m_axis_tdest,
  output logic [M_COUNT-1:0]               m_axis_tvalid,
  input  logic [M_COUNT-1:0]               m_axis_tready,
  output logic [M_COUNT-1:0]               m_axis_tlast,

  output logic [31:0]                      drop_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FORWARD = 2'd1,
    DROP    = 2'd2
  } state_t;

  localparam logic [SEL_WIDTH:0] PORT_LIMIT = (SEL_WIDTH + 1)'(M_COUNT);

  state_t                 state_q;
  logic                   sel_ready_q;
  logic [SEL_WIDTH-1:0]   cur_port_q;
  logic [SEL_WIDTH-1:0]   out_port_q;
  logic                   out_valid_q;
  logic                   out_last_q;
  logic [DATA_WIDTH-1:0]  out_data_q;
  logic [KEEP_WIDTH-1:0]  out_keep_q;
  logic [USER_WIDTH-1:0]  out_user_q;
  logic [ID_WIDTH-1:0]    out_id_q;
  logic [DEST_WIDTH-1:0]  out_dest_q;
  logic [31:0]            drop_count_q;
  logic [31:0]            drop_count_d;

  logic out_tready;
  logic s_ready;
  logic s_fire;
  logic sel_fire;
  logic port_oob;

  always_comb begin
    out_tready = 1'b0;
    for (int i = 0; i < M_COUNT; i++) begin
      if (out_port_q == SEL_WIDTH'(i)) out_tready = m_axis_tready[i];
    end
  end

  // The next beat may only enter once the shared register is free or draining,
  // which also keeps consecutive packets to different ports strictly ordered.
  always_comb begin
    case (state_q)
      FORWARD: s_ready = !out_valid_q || out_tready;
      DROP:    s_ready = 1'b1;
      default: s_ready = 1'b0;
    endcase
  end

  assign s_axis_tready = s_ready;
  assign sel_ready     = sel_ready_q;
  assign s_fire        = s_axis_tvalid && s_ready;
  assign sel_fire      = sel_valid && sel_ready_q;
  assign port_oob      = (M_COUNT > 1) && ({1'b0, sel_port} >= PORT_LIMIT);
  assign drop_count_d  = (drop_count_q == 32'hFFFF_FFFF) ? drop_count_q : drop_count_q + 32'd1;
  assign drop_count    = drop_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_ready_q  <= 1'b0;
      cur_port_q   <= '0;
      out_port_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_user_q   <= '0;
      out_id_q     <= '0;
      out_dest_q   <= '0;
      drop_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          sel_ready_q <= 1'b1;
          if (sel_fire) begin
            sel_ready_q <= 1'b0;
            if (sel_drop || port_oob) begin
              state_q <= DROP;
            end else begin
              state_q    <= FORWARD;
              cur_port_q <= (M_COUNT > 1) ? sel_port : '0;
            end
          end
        end
        FORWARD: begin
          if (s_fire && s_axis_tlast) begin
            state_q     <= IDLE;
            sel_ready_q <= 1'b1;
          end
        end
        DROP: begin
          if (s_fire && s_axis_tlast) begin
            state_q      <= IDLE;
            sel_ready_q  <= 1'b1;
            drop_count_q <= drop_count_d;
          end
        end
        default: begin
          state_q     <= IDLE;
          sel_ready_q <= 1'b0;
        end
      endcase

      if (state_q == FORWARD && s_fire) begin
        out_valid_q <= 1'b1;
        out_port_q  <= cur_port_q;
        out_last_q  <= s_axis_tlast;
        out_data_q  <= s_axis_tdata;
        out_keep_q  <= s_axis_tkeep;
        out_user_q  <= s_axis_tuser;
        out_id_q    <= s_axis_tid;
        out_dest_q  <= s_axis_tdest;
      end else if (out_tready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < M_COUNT; i++) begin : g_port
    logic hit;
    assign hit = (out_port_q == SEL_WIDTH'(i));
    assign m_axis_tvalid[i] = hit && out_valid_q;
    assign m_axis_tlast[i]  = hit && out_last_q;
    assign m_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH] = hit ? out_data_q : '0;
    assign m_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH] = hit ? out_keep_q : '0;
    assign m_axis_tuser[i*USER_WIDTH +: USER_WIDTH] = hit ? out_user_q : '0;
    assign m_axis_tid[i*ID_WIDTH +: ID_WIDTH]       = hit ? out_id_q   : '0;
    assign m_axis_tdest[i*DEST_WIDTH +: DEST_WIDTH] = hit ? out_dest_q : '0;
  end

endmodule
